icache_data_ram_arbiter: RTL and testbench

- Shares the single-port L1.5 instruction-cache data RAM between two requesters: the lookup read path (fetch hits) and the refill write path (line fills from L2).
- Writer has priority, and a refill burst locks the RAM. A bounded starvation counter guarantees reads forward progress.
- Sits between the cache controller and the data RAM wrapper, and drives the RAM req/write/addr/wdata/be pins directly.

---
 rtl/icache_data_arb_pkg.sv | 18 +
 rtl/icache_data_ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_icache_data_ram_arbiter.sv | 210 +++++++++++++++++++++
 3 files changed

// File: rtl/icache_data_arb_pkg.sv
// Shared types for the L1.5 icache data RAM arbiter: FSM states, RAM port
// select encoding and the starvation counter width.
package icache_data_arb_pkg;

  localparam int STARVE_CNT_W = 4;

  typedef enum logic [0:0] {
    IDLE     = 1'b0,
    WR_BURST = 1'b1
  } arb_state_e;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_RD   = 2'd1,
    SEL_WR   = 2'd2
  } arb_sel_e;

endpackage

// File: rtl/icache_data_ram_arbiter.sv
// Arbitrates the single-port icache data RAM between fetch-hit reads and
// refill writes; refill bursts lock the RAM, a starvation counter forces reads.
module icache_data_ram_arbiter
  import icache_data_arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 7,
  parameter int DATA_WIDTH = 64,
  parameter int BE_WIDTH   = DATA_WIDTH / 8,
  parameter int MAX_STARVE = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rd_req_i,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic                  rd_gnt_o,
  output logic                  rd_rvalid_o,
  output logic [DATA_WIDTH-1:0] rd_rdata_o,
  input  logic                  wr_req_i,
  input  logic [ADDR_WIDTH-1:0] wr_addr_i,
  input  logic [DATA_WIDTH-1:0] wr_wdata_i,
  input  logic [BE_WIDTH-1:0]   wr_be_i,
  input  logic                  wr_last_i,
  output logic                  wr_gnt_o,
  output logic                  ram_req_o,
  output logic                  ram_write_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic [DATA_WIDTH-1:0] ram_wdata_o,
  output logic [BE_WIDTH-1:0]   ram_be_o,
  input  logic [DATA_WIDTH-1:0] ram_rdata_i
);

  localparam logic [STARVE_CNT_W-1:0] MAX_STARVE_C = STARVE_CNT_W'(MAX_STARVE);
  localparam logic [STARVE_CNT_W-1:0] CNT_ONE_C    = STARVE_CNT_W'(1);

  arb_state_e              state_r;
  arb_state_e              state_nxt_s;
  arb_sel_e                sel_s;
  logic [STARVE_CNT_W-1:0] starve_cnt_r;
  logic                    force_rd_s;
  logic                    rd_rvalid_r;

  assign force_rd_s  = rd_req_i & (starve_cnt_r == MAX_STARVE_C);
  assign rd_rdata_o  = ram_rdata_i;
  assign rd_rvalid_o = rd_rvalid_r;

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state: only a granted write beat moves the lock in or out
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      IDLE: begin
        if ((sel_s == SEL_WR) && !wr_last_i) begin
          state_nxt_s = WR_BURST;
        end else begin
          state_nxt_s = IDLE;
        end
      end
      WR_BURST: begin
        if ((sel_s == SEL_WR) && wr_last_i) begin
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = WR_BURST;
        end
      end
      default: state_nxt_s = IDLE;
    endcase
  end

  // Grant decode and RAM pin mux; a forced read overrides even a locked burst
  always_comb begin
    sel_s = SEL_NONE;
    if (rst) begin
      sel_s = SEL_NONE;
    end else if (force_rd_s) begin
      sel_s = SEL_RD;
    end else begin
      case (state_r)
        IDLE: begin
          if (wr_req_i) begin
            sel_s = SEL_WR;
          end else if (rd_req_i) begin
            sel_s = SEL_RD;
          end else begin
            sel_s = SEL_NONE;
          end
        end
        WR_BURST: begin
          if (wr_req_i) begin
            sel_s = SEL_WR;
          end else begin
            sel_s = SEL_NONE;
          end
        end
        default: sel_s = SEL_NONE;
      endcase
    end

    rd_gnt_o    = 1'b0;
    wr_gnt_o    = 1'b0;
    ram_addr_o  = {ADDR_WIDTH{1'b0}};
    ram_wdata_o = {DATA_WIDTH{1'b0}};
    ram_be_o    = {BE_WIDTH{1'b0}};
    case (sel_s)
      SEL_RD: begin
        rd_gnt_o   = 1'b1;
        ram_addr_o = rd_addr_i;
      end
      SEL_WR: begin
        wr_gnt_o    = 1'b1;
        ram_addr_o  = wr_addr_i;
        ram_wdata_o = wr_wdata_i;
        ram_be_o    = wr_be_i;
      end
      default: begin
        rd_gnt_o = 1'b0;
        wr_gnt_o = 1'b0;
      end
    endcase
    ram_req_o   = rd_gnt_o | wr_gnt_o;
    ram_write_o = wr_gnt_o;
  end

  // Starvation counter: counts ungranted read cycles, saturating
  always_ff @(posedge clk) begin
    if (rst) begin
      starve_cnt_r <= {STARVE_CNT_W{1'b0}};
    end else if (rd_gnt_o) begin
      starve_cnt_r <= {STARVE_CNT_W{1'b0}};
    end else if (rd_req_i && (starve_cnt_r != MAX_STARVE_C)) begin
      starve_cnt_r <= starve_cnt_r + CNT_ONE_C;
    end else begin
      starve_cnt_r <= starve_cnt_r;
    end
  end

  // Read-data valid follows the read grant by one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_rvalid_r <= 1'b0;
    end else begin
      rd_rvalid_r <= rd_gnt_o;
    end
  end

endmodule

// File: tb/tb_icache_data_ram_arbiter.sv
// Randomized bench for icache_data_ram_arbiter: random read/refill requesters,
// a behavioural RAM, and a reference model of the arbitration rules.
module tb_icache_data_ram_arbiter;

  localparam int AW   = 7;
  localparam int DW   = 64;
  localparam int BW   = DW / 8;
  localparam int MS   = 4;
  localparam int NCYC = 6000;
  localparam int NPRE = 128;

  logic          clk = 1'b0;
  logic          rst;
  logic          rd_req;
  logic [AW-1:0] rd_addr;
  logic          rd_gnt;
  logic          rd_rvalid;
  logic [DW-1:0] rd_rdata;
  logic          wr_req;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_wdata;
  logic [BW-1:0] wr_be;
  logic          wr_last;
  logic          wr_gnt;
  logic          ram_req;
  logic          ram_write;
  logic [AW-1:0] ram_addr;
  logic [DW-1:0] ram_wdata;
  logic [BW-1:0] ram_be;
  logic [DW-1:0] ram_rdata;

  always #5 clk = ~clk;

  icache_data_ram_arbiter #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BE_WIDTH(BW), .MAX_STARVE(MS)
  ) dut (
    .clk(clk), .rst(rst),
    .rd_req_i(rd_req), .rd_addr_i(rd_addr), .rd_gnt_o(rd_gnt),
    .rd_rvalid_o(rd_rvalid), .rd_rdata_o(rd_rdata),
    .wr_req_i(wr_req), .wr_addr_i(wr_addr), .wr_wdata_i(wr_wdata),
    .wr_be_i(wr_be), .wr_last_i(wr_last), .wr_gnt_o(wr_gnt),
    .ram_req_o(ram_req), .ram_write_o(ram_write), .ram_addr_o(ram_addr),
    .ram_wdata_o(ram_wdata), .ram_be_o(ram_be), .ram_rdata_i(ram_rdata)
  );

  // Behavioural single-port RAM with byte enables and 1-cycle read latency
  logic [DW-1:0] mem [0:(1<<AW)-1];
  logic [DW-1:0] ram_rdata_q;
  logic          pl_en;
  logic [AW-1:0] pl_addr;
  logic [DW-1:0] pl_data;
  always @(posedge clk) begin
    if (pl_en) begin
      mem[pl_addr] <= pl_data;
    end else if (ram_req) begin
      if (ram_write) begin
        for (int b = 0; b < BW; b++) begin
          if (ram_be[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
      end else begin
        ram_rdata_q <= mem[ram_addr];
      end
    end
  end
  assign ram_rdata = ram_rdata_q;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // reference model state
  logic [DW-1:0] gold [0:(1<<AW)-1];
  logic          locked;
  int            waited;
  logic          m_rv;
  logic [DW-1:0] m_rdata;
  logic          eg_rd, eg_wr, force_c;
  logic [AW-1:0] e_addr;
  logic [DW-1:0] e_wdata;
  logic [BW-1:0] e_be;
  // requester state
  logic          burst_active;
  int            burst_len, burst_idx;
  logic [AW-1:0] burst_base;
  int            rd_pct, wr_start_pct, wr_cont_pct;
  // scenario coverage
  int            n_forced_burst, n_gap_block, n_b2b, n_be_partial, n_single;
  logic          prev_rd;

  initial begin
    rst = 1'b1; rd_req = 1'b0; rd_addr = '0; wr_req = 1'b0; wr_addr = '0;
    wr_wdata = '0; wr_be = '0; wr_last = 1'b0;
    pl_en = 1'b1; pl_addr = '0; pl_data = {$urandom, $urandom};
    gold[0] = pl_data;
    locked = 1'b0; waited = 0; m_rv = 1'b0; m_rdata = '0; prev_rd = 1'b0;
    burst_active = 1'b0; burst_len = 0; burst_idx = 0; burst_base = '0;
    n_forced_burst = 0; n_gap_block = 0; n_b2b = 0; n_be_partial = 0; n_single = 0;

    for (int cyc = 0; cyc < NCYC; cyc++) begin
      @(negedge clk);
      force_c = rd_req && (waited == MS);
      eg_rd = 1'b0;
      eg_wr = 1'b0;
      if (!rst) begin
        if (force_c) eg_rd = 1'b1;
        else if (locked) eg_wr = wr_req;
        else if (wr_req) eg_wr = 1'b1;
        else if (rd_req) eg_rd = 1'b1;
      end
      e_addr  = eg_rd ? rd_addr : (eg_wr ? wr_addr : '0);
      e_wdata = eg_wr ? wr_wdata : '0;
      e_be    = eg_wr ? wr_be : '0;

      check_eq("rd_gnt", 64'(rd_gnt), 64'(eg_rd));
      check_eq("wr_gnt", 64'(wr_gnt), 64'(eg_wr));
      check_eq("ram_req", 64'(ram_req), 64'(eg_rd | eg_wr));
      check_eq("ram_write", 64'(ram_write), 64'(eg_wr));
      check_eq("ram_addr", 64'(ram_addr), 64'(e_addr));
      check_eq("ram_wdata", ram_wdata, e_wdata);
      check_eq("ram_be", 64'(ram_be), 64'(e_be));
      if (cyc >= 2) begin
        check_eq("rd_rvalid", 64'(rd_rvalid), 64'(m_rv));
        if (m_rv) check_eq("rd_rdata", rd_rdata, m_rdata);
      end

      if (eg_rd && locked && wr_req) n_forced_burst++;
      if (!rst && locked && !wr_req && rd_req && !force_c) n_gap_block++;
      if (eg_rd && prev_rd) n_b2b++;
      if (eg_wr && wr_be != '1) n_be_partial++;
      if (eg_wr && !locked && wr_last) n_single++;
      prev_rd = eg_rd;

      // advance the model by one clock
      if (eg_rd) m_rdata = gold[rd_addr];
      if (eg_wr) begin
        for (int b = 0; b < BW; b++) begin
          if (wr_be[b]) gold[wr_addr][8*b +: 8] = wr_wdata[8*b +: 8];
        end
      end
      if (rst) begin
        locked = 1'b0; waited = 0; m_rv = 1'b0;
      end else begin
        if (eg_wr) locked = !wr_last;
        if (eg_rd) waited = 0;
        else if (rd_req && waited < MS) waited++;
        m_rv = eg_rd;
      end

      @(posedge clk);
      #1;
      case ((cyc / 1000) % 3)
        0: begin rd_pct = 100; wr_start_pct = 5;  wr_cont_pct = 50; end
        1: begin rd_pct = 70;  wr_start_pct = 80; wr_cont_pct = 95; end
        default: begin rd_pct = 50; wr_start_pct = 25; wr_cont_pct = 60; end
      endcase

      pl_en = (cyc + 1) < NPRE;
      if (pl_en) begin
        pl_addr = AW'(cyc + 1);
        pl_data = {$urandom, $urandom};
        gold[pl_addr] = pl_data;
      end
      rst = pl_en || ($urandom_range(199) == 0);

      // reader: hold until granted, then maybe issue the next read
      if (rd_req && eg_rd) rd_req = 1'b0;
      if (!rd_req && !pl_en && $urandom_range(99) < rd_pct) begin
        rd_req  = 1'b1;
        rd_addr = AW'($urandom);
      end

      // refill writer: bursts of 1..10 beats with random gaps
      if (wr_req && eg_wr) begin
        wr_req = 1'b0;
        burst_idx++;
        if (wr_last) burst_active = 1'b0;
      end
      if (!burst_active && !pl_en && $urandom_range(99) < wr_start_pct) begin
        burst_active = 1'b1;
        burst_len    = $urandom_range(1, 10);
        burst_idx    = 0;
        burst_base   = AW'($urandom);
      end
      if (burst_active && !wr_req && $urandom_range(99) < wr_cont_pct) begin
        wr_req   = 1'b1;
        wr_addr  = AW'(burst_base + AW'(burst_idx));
        wr_wdata = ($urandom_range(3) == 0) ? {DW{1'b1}} : {$urandom, $urandom};
        wr_be    = BW'($urandom);
        wr_last  = (burst_idx == burst_len - 1);
      end
    end

    check_eq("cov_forced_in_burst", 64'(n_forced_burst > 0), 64'd1);
    check_eq("cov_burst_gap_blocks_rd", 64'(n_gap_block > 0), 64'd1);
    check_eq("cov_b2b_reads", 64'(n_b2b > 0), 64'd1);
    check_eq("cov_partial_be", 64'(n_be_partial > 0), 64'd1);
    check_eq("cov_single_beat", 64'(n_single > 0), 64'd1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
